// File: rtl/pir_pkg.sv
// Shared types and constants for the PIR input conditioner and its consumers.
package pir_pkg;

  localparam int MAX_SENSORS  = 4;
  localparam int SENSOR_IDX_W = 2;
  localparam int DROP_CNT_W   = 8;

  typedef struct packed {
    logic [SENSOR_IDX_W-1:0] sensor;
  } pir_event_t;

  // Saturating add of up to MAX_SENSORS drops per cycle.
  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                    input logic [2:0]            b);
    logic [DROP_CNT_W:0] s;
    s = {1'b0, a} + {{(DROP_CNT_W-2){1'b0}}, b};
    return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pir_input_conditioner_if.sv
// Motion-event handshake between the input conditioner (master) and the alarm controller (slave).
interface pir_input_conditioner_if;
  import pir_pkg::*;

  logic                    evt_valid;
  logic                    evt_ready;
  logic [SENSOR_IDX_W-1:0] evt_sensor;

  modport master (output evt_valid, output evt_sensor, input evt_ready);
  modport slave  (input evt_valid, input evt_sensor, output evt_ready);
endinterface

// File: rtl/pir_debounce.sv
// Per-channel 2-flop synchroniser, debounce counter and rising-edge pulse of the debounced level.
module pir_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_in};
      rise   <= 1'b0;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Input has differed for DEBOUNCE_CYCLES samples in a row: accept it.
        level <= ~level;
        rise  <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pir_input_conditioner.sv
// PIR front end: debounce, arm/lockout qualification and a FWFT event FIFO.
// Optional arm warm-up blanking is compiled in with `define PIR_WARMUP_EN.
module pir_input_conditioner
  import pir_pkg::*;
#(
  parameter int NUM_SENSORS     = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 1024,
  parameter int FIFO_DEPTH      = 4,
  parameter int WARMUP_CYCLES   = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     turn,
  input  logic [NUM_SENSORS-1:0]   raw_pir,
  pir_input_conditioner_if.master  evt_if,
  output logic [NUM_SENSORS-1:0]   sensor_level,
  output logic                     armed,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);

  logic [NUM_SENSORS-1:0]  rise, pending, qual, push_mask, drop_mask, lock_busy;
  logic [LOCK_W-1:0]       lockout [NUM_SENSORS];
  pir_event_t              fifo_mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    empty, full, push, pop, found;
  logic [SENSOR_IDX_W-1:0] push_idx;
  logic [2:0]              drop_n;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    pir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw_in (raw_pir[i]),
      .level  (sensor_level[i]),
      .rise   (rise[i])
    );
    assign lock_busy[i] = (lockout[i] != '0);
  end

  assign empty             = (wr_ptr == rd_ptr);
  assign full              = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_if.evt_valid  = !empty;
  assign evt_if.evt_sensor = empty ? '0 : fifo_mem[rd_ptr[AW-1:0]].sensor;
  assign pop               = evt_if.evt_valid && evt_if.evt_ready;

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    push_idx  = '0;
    found     = 1'b0;
    push_mask = '0;
    qual      = '0;
    drop_mask = '0;
    drop_n    = '0;
    // Descending scan leaves the lowest pending index selected.
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_idx = SENSOR_IDX_W'(i);
        found    = 1'b1;
      end
    end
    push = armed && found && (!full || pop);
    for (int i = 0; i < NUM_SENSORS; i++) begin
      push_mask[i] = push && (push_idx == SENSOR_IDX_W'(i));
      qual[i]      = rise[i] && armed && !lock_busy[i];
      drop_mask[i] = qual[i] && pending[i] && !push_mask[i];
      drop_n       = drop_n + {2'b00, drop_mask[i]};
    end
  end

  // Disarming flushes queued and pending events as well as lockouts.
  always_ff @(posedge clk) begin
    if (reset || !armed) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) lockout[i] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      pending <= (pending & ~push_mask) | qual;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (qual[i])           lockout[i] <= LOCK_LOAD;
        else if (lock_busy[i]) lockout[i] <= lockout[i] - LOCK_W'(1);
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{sensor: push_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else       drop_count <= sat_add(drop_count, drop_n);
  end

`ifdef PIR_WARMUP_EN
  localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
  logic [WARM_W-1:0] warm_cnt;
  logic              warming;

  // Arming waits out WARMUP_CYCLES after turn rises; turn low aborts it.
  always_ff @(posedge clk) begin
    if (reset || !turn) begin
      armed    <= 1'b0;
      warming  <= 1'b0;
      warm_cnt <= '0;
    end else if (!armed) begin
      if (!warming) begin
        warming  <= 1'b1;
        warm_cnt <= WARM_W'(WARMUP_CYCLES - 1);
      end else if (warm_cnt == '0) begin
        armed   <= 1'b1;
        warming <= 1'b0;
      end else begin
        warm_cnt <= warm_cnt - WARM_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) armed <= 1'b0;
    else       armed <= turn;
  end
`endif

endmodule

// File: tb/tb_pir_input_conditioner.sv
// Directed bench for pir_input_conditioner with a scoreboard of expected event indices.
module tb_pir_input_conditioner;
  import pir_pkg::*;

  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            turn;
  logic [NS-1:0]   raw_pir;
  logic [NS-1:0]   sensor_level;
  logic            armed;
  logic [7:0]      drop_count;
  int              total = 0;
  int              bad   = 0;
  int              sb_q[$];
  logic [NS-1:0]   lvl_seen;
  logic            v_seen;

  pir_input_conditioner_if evt_bus ();

  pir_input_conditioner #(
    .NUM_SENSORS     (NS),
    .DEBOUNCE_CYCLES (4),
    .LOCKOUT_CYCLES  (16),
    .FIFO_DEPTH      (4),
    .WARMUP_CYCLES   (4096)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .turn         (turn),
    .raw_pir      (raw_pir),
    .evt_if       (evt_bus.master),
    .sensor_level (sensor_level),
    .armed        (armed),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_armed();
    for (int k = 0; k < 6000 && !armed; k++) tick();
    check("armed_wait", armed, 1);
  endtask

  task automatic pulse_ch0();
    raw_pir[0] = 1'b1;
    repeat (8) tick();
    raw_pir[0] = 1'b0;
    repeat (16) tick();
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected index.
  always @(negedge clk) begin
    int e;
    if (!reset && evt_bus.evt_valid && evt_bus.evt_ready) begin
      total++;
      assert (sb_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_evt observed=%0d expected=none", evt_bus.evt_sensor);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_evt_sensor", evt_bus.evt_sensor, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    turn              = 1'b1;
    raw_pir           = '0;
    evt_bus.evt_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid",  evt_bus.evt_valid, 0);
    check("rst_sensor", evt_bus.evt_sensor, 0);
    check("rst_level",  sensor_level, 0);
    check("rst_armed",  armed, 0);
    check("rst_drop",   drop_count, 0);
    reset = 1'b0;
`ifdef PIR_WARMUP_EN
    wait_armed();
`else
    repeat (2) tick();
    check("arm_after_reset", armed, 1);
`endif

    // Glitch rejection: three high samples are one short of the threshold.
    lvl_seen = '0;
    v_seen   = 1'b0;
    raw_pir[1] = 1'b1;
    repeat (3) tick();
    raw_pir[1] = 1'b0;
    repeat (12) begin
      tick();
      lvl_seen |= sensor_level;
      v_seen   |= evt_bus.evt_valid;
    end
    check("glitch_level", lvl_seen, 0);
    check("glitch_valid", v_seen, 0);

    // Single event latency: visible after edge N+7 for one cycle.
    evt_bus.evt_ready = 1'b1;
    sb_q.push_back(2);
    raw_pir[2] = 1'b1;
    repeat (7) tick();
    check("single_pre", evt_bus.evt_valid, 0);
    tick();
    check("single_valid", evt_bus.evt_valid, 1);
    check("single_sensor", evt_bus.evt_sensor, 2);
    tick();
    check("single_post", evt_bus.evt_valid, 0);

    // Retrigger inside the lockout window is ignored.
    v_seen = 1'b0;
    raw_pir[2] = 1'b0;
    repeat (6) tick();
    raw_pir[2] = 1'b1;
    repeat (20) begin
      tick();
      v_seen |= evt_bus.evt_valid;
    end
    check("retrig_level", sensor_level[2], 1);
    check("retrig_valid", v_seen, 0);
    raw_pir[2] = 1'b0;
    repeat (30) tick();

    // Simultaneous channels queue in ascending order.
    evt_bus.evt_ready = 1'b0;
    sb_q.push_back(0);
    sb_q.push_back(1);
    sb_q.push_back(2);
    raw_pir = 3'b111;
    repeat (12) tick();
    check("simul_level", sensor_level, 3'b111);
    check("simul_head_valid", evt_bus.evt_valid, 1);
    check("simul_head0", evt_bus.evt_sensor, 0);
    evt_bus.evt_ready = 1'b1;
    tick();
    check("simul_head1", evt_bus.evt_sensor, 1);
    tick();
    check("simul_head2", evt_bus.evt_sensor, 2);
    tick();
    check("simul_empty", evt_bus.evt_valid, 0);
    raw_pir = '0;
    repeat (30) tick();

    // Overflow: 4 queued, 1 pending, then every further edge is a drop.
    evt_bus.evt_ready = 1'b0;
    repeat (5) sb_q.push_back(0);
    repeat (6) pulse_ch0();
    check("ovf_drop1", drop_count, 1);
    check("ovf_valid", evt_bus.evt_valid, 1);
    repeat (299) pulse_ch0();
    check("ovf_saturate", drop_count, 255);
    evt_bus.evt_ready = 1'b1;
    repeat (10) tick();
    check("ovf_drain", sb_q.size(), 0);
    check("ovf_drain_valid", evt_bus.evt_valid, 0);

    // Disarm flushes the queue; edges while disarmed are not queued.
    evt_bus.evt_ready = 1'b0;
    raw_pir = 3'b111;
    repeat (12) tick();
    check("disarm_pre_valid", evt_bus.evt_valid, 1);
    raw_pir = '0;
    repeat (10) tick();
    turn = 1'b0;
    tick();
    check("disarm_armed", armed, 0);
    check("disarm_valid_hold", evt_bus.evt_valid, 1);
    tick();
    check("disarm_flush", evt_bus.evt_valid, 0);
    v_seen  = 1'b0;
    raw_pir = 3'b111;
    repeat (12) begin
      tick();
      v_seen |= evt_bus.evt_valid;
    end
    check("disarm_level", sensor_level, 3'b111);
    turn = 1'b1;
`ifdef PIR_WARMUP_EN
    wait_armed();
`else
    tick();
    check("rearm", armed, 1);
`endif
    repeat (4) begin
      tick();
      v_seen |= evt_bus.evt_valid;
    end
    check("disarm_no_evt", v_seen, 0);
    raw_pir = '0;
    repeat (30) tick();

    // Reset mid-stream with two queued events and active lockouts.
    raw_pir = 3'b011;
    repeat (12) tick();
    check("rst_mid_pre", evt_bus.evt_valid, 1);
    reset   = 1'b1;
    raw_pir = '0;
    tick();
    check("rst_mid_valid",  evt_bus.evt_valid, 0);
    check("rst_mid_sensor", evt_bus.evt_sensor, 0);
    check("rst_mid_level",  sensor_level, 0);
    check("rst_mid_armed",  armed, 0);
    check("rst_mid_drop",   drop_count, 0);
    reset = 1'b0;
    wait_armed();
    evt_bus.evt_ready = 1'b1;
    sb_q.push_back(0);
    raw_pir[0] = 1'b1;
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) tick();
    check("rst_lockout_cleared", sb_q.size(), 0);
    raw_pir = '0;
    repeat (30) tick();

`ifdef PIR_WARMUP_EN
    // Edges during warm-up are ignored; one after it is queued.
    turn = 1'b0;
    repeat (2) tick();
    turn   = 1'b1;
    v_seen = 1'b0;
    tick();
    raw_pir[0] = 1'b1;
    repeat (10) tick();
    raw_pir[0] = 1'b0;
    repeat (20) begin
      tick();
      v_seen |= evt_bus.evt_valid;
    end
    check("warm_ignored", v_seen, 0);
    check("warm_not_armed", armed, 0);
    wait_armed();
    sb_q.push_back(0);
    raw_pir[0] = 1'b1;
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) tick();
    check("warm_evt", sb_q.size(), 0);
    raw_pir = '0;
    repeat (5) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
